// File: rtl/game_controller_if.sv
// Game controller signal bundle: player/timer inputs and display/timer outputs.
// The controller connects through the slave modport and the surrounding system
// through the master modport.
interface game_controller_if;
    logic       loggedIn;
    logic       startPulse;
    logic [3:0] userInput;
    logic       pulse2s;
    logic       timeout;
    logic       twoSecEnable;
    logic       timerReconfig;
    logic       timerEnable;
    logic [1:0] gameLevel;
    logic [3:0] randDigit;
    logic [3:0] playerDigit;
    logic [3:0] scoreTens;
    logic [3:0] scoreOnes;
    logic       GCLogout;

    modport master (
        output loggedIn, startPulse, userInput, pulse2s, timeout,
        input  twoSecEnable, timerReconfig, timerEnable, gameLevel,
               randDigit, playerDigit, scoreTens, scoreOnes, GCLogout
    );

    modport slave (
        input  loggedIn, startPulse, userInput, pulse2s, timeout,
        output twoSecEnable, timerReconfig, timerEnable, gameLevel,
               randDigit, playerDigit, scoreTens, scoreOnes, GCLogout
    );
endinterface

// File: rtl/game_controller.sv
// Memory-digit game controller: shows a pseudo-random digit for two seconds,
// then the player must enter it before the countdown expires. Score is BCD
// (saturates at 99), level saturates at 3. All outputs are registered and are
// computed from the next state, so they line up with the state they belong to.
// Optional feature: define GC_LIVES_EN to give the player 3 lives per game.
module game_controller (
    input  logic             clk,
    input  logic             rst,
    game_controller_if.slave gc
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHOW  = 3'd2;
    localparam logic [2:0] GUESS = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] OVER  = 3'd5;
    localparam logic [3:0] BLANK = 4'hF;

    logic [2:0] state, next_state;
    logic [3:0] lfsr;
    logic [3:0] digit;
    logic [3:0] guess;
    logic       match;
`ifdef GC_LIVES_EN
    logic [1:0] lives;
`endif

    // Fold the 1..15 LFSR value into 0..9.
    function automatic logic [3:0] to_digit(input logic [3:0] v);
        return (v >= 4'd10) ? v - 4'd10 : v;
    endfunction

    // Out-of-range guesses (10..15) can never equal a folded digit.
    assign match = (guess == digit);

    // Next-state selection; a dropped session beats every other transition.
    always_comb begin
        next_state = state;
        if (!gc.loggedIn) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (gc.startPulse) next_state = LOAD;
                LOAD:    next_state = SHOW;
                SHOW:    if (gc.pulse2s) next_state = GUESS;
                GUESS: begin
                    // Timeout wins over a simultaneous submit.
                    if (gc.timeout)         next_state = OVER;
                    else if (gc.startPulse) next_state = CHECK;
                end
                CHECK: begin
                    if (match) next_state = LOAD;
`ifdef GC_LIVES_EN
                    else if (lives != 2'd1) next_state = LOAD;
`endif
                    else next_state = OVER;
                end
                OVER:    if (gc.startPulse) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // State, digit source, game bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            lfsr             <= 4'b0001;
            digit            <= 4'd0;
            guess            <= 4'd0;
            gc.gameLevel     <= 2'd0;
            gc.scoreTens     <= 4'd0;
            gc.scoreOnes     <= 4'd0;
            gc.randDigit     <= BLANK;
            gc.playerDigit   <= BLANK;
            gc.twoSecEnable  <= 1'b0;
            gc.timerReconfig <= 1'b0;
            gc.timerEnable   <= 1'b0;
            gc.GCLogout      <= 1'b0;
`ifdef GC_LIVES_EN
            lives            <= 2'd0;
`endif
        end else begin
            state <= next_state;
            // x^4+x^3+1, maximal length, never reaches zero from a non-zero seed.
            lfsr  <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};

            // The round's digit is the LFSR value in the cycle the load is triggered.
            if (next_state == LOAD)
                digit <= to_digit(lfsr);

            if (state == GUESS && next_state == CHECK)
                guess <= gc.userInput;

            // New game: clear score and level.
            if (state == IDLE && next_state == LOAD) begin
                gc.gameLevel <= 2'd0;
                gc.scoreTens <= 4'd0;
                gc.scoreOnes <= 4'd0;
`ifdef GC_LIVES_EN
                lives        <= 2'd3;
`endif
            end

            if (state == CHECK && next_state == LOAD) begin
                if (match) begin
                    if (gc.gameLevel != 2'd3)
                        gc.gameLevel <= gc.gameLevel + 2'd1;
                    if (!(gc.scoreTens == 4'd9 && gc.scoreOnes == 4'd9)) begin
                        if (gc.scoreOnes == 4'd9) begin
                            gc.scoreOnes <= 4'd0;
                            gc.scoreTens <= gc.scoreTens + 4'd1;
                        end else begin
                            gc.scoreOnes <= gc.scoreOnes + 4'd1;
                        end
                    end
                end
`ifdef GC_LIVES_EN
                else begin
                    lives <= lives - 2'd1;
                end
`endif
            end

            gc.timerReconfig <= (next_state == LOAD);
            gc.twoSecEnable  <= (next_state == SHOW);
            gc.timerEnable   <= (next_state == GUESS);
            gc.randDigit     <= (next_state == SHOW) ? digit : BLANK;
            gc.playerDigit   <= (next_state == GUESS || next_state == CHECK) ? gc.userInput : BLANK;
            gc.GCLogout      <= gc.loggedIn && (state == OVER) && gc.startPulse;
        end
    end
endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: a rule-level model of the game predicts every
// output after each clock edge; directed rounds pin key values with literals,
// then a randomized phase runs against the same model.
module tb_game_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_controller_if gc();
    game_controller dut (.clk(clk), .rst(rst), .gc(gc));

    int tests = 0;
    int fails = 0;

    localparam int S_IDLE = 0, S_LOAD = 1, S_SHOW = 2, S_GUESS = 3, S_CHECK = 4, S_OVER = 5;

    int m_state, m_lfsr, m_digit, m_guess, m_score, m_level, m_lives;
    int e_rand, e_player, e_reconf, e_two, e_ten, e_logout;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the game model by one clock given the inputs held during the cycle.
    task automatic model_step(input bit r, input bit li, input bit sp, input int ui,
                              input bit p2, input bit to);
        int ns;
        int lf;
        e_logout = 0;
        if (r) begin
            m_state = S_IDLE; m_lfsr = 1; m_level = 0; m_score = 0; m_lives = 0;
            e_rand = 15; e_player = 15; e_reconf = 0; e_two = 0; e_ten = 0;
        end else begin
            lf = m_lfsr;
            m_lfsr = ((lf << 1) & 15) | (((lf >> 3) ^ (lf >> 2)) & 1);
            ns = m_state;
            if (!li) ns = S_IDLE;
            else case (m_state)
                S_IDLE: if (sp) begin
                    m_score = 0; m_level = 0; m_lives = 3; m_digit = lf % 10; ns = S_LOAD;
                end
                S_LOAD: ns = S_SHOW;
                S_SHOW: if (p2) ns = S_GUESS;
                S_GUESS: begin
                    if (to) ns = S_OVER;
                    else if (sp) begin m_guess = ui; ns = S_CHECK; end
                end
                S_CHECK: begin
                    if (m_guess == m_digit) begin
                        if (m_score < 99) m_score++;
                        if (m_level < 3) m_level++;
                        m_digit = lf % 10; ns = S_LOAD;
                    end else begin
`ifdef GC_LIVES_EN
                        if (m_lives > 1) begin m_lives--; m_digit = lf % 10; ns = S_LOAD; end
                        else ns = S_OVER;
`else
                        ns = S_OVER;
`endif
                    end
                end
                S_OVER: if (sp) begin e_logout = 1; ns = S_IDLE; end
                default: ns = S_IDLE;
            endcase
            m_state  = ns;
            e_reconf = (ns == S_LOAD);
            e_two    = (ns == S_SHOW);
            e_ten    = (ns == S_GUESS);
            e_rand   = (ns == S_SHOW) ? m_digit : 15;
            e_player = (ns == S_GUESS || ns == S_CHECK) ? ui : 15;
        end
    endtask

    task automatic compare_all();
        chk("timerReconfig", gc.timerReconfig, e_reconf);
        chk("twoSecEnable",  gc.twoSecEnable,  e_two);
        chk("timerEnable",   gc.timerEnable,   e_ten);
        chk("randDigit",     gc.randDigit,     e_rand);
        chk("playerDigit",   gc.playerDigit,   e_player);
        chk("GCLogout",      gc.GCLogout,      e_logout);
        chk("gameLevel",     gc.gameLevel,     m_level);
        chk("scoreTens",     gc.scoreTens,     m_score / 10);
        chk("scoreOnes",     gc.scoreOnes,     m_score % 10);
    endtask

    // One clock: drive inputs, step the model, sample 1ns after the edge.
    task automatic cyc(input bit r, input bit li, input bit sp, input int ui,
                       input bit p2, input bit to);
        rst           = r;
        gc.loggedIn   = li;
        gc.startPulse = sp;
        gc.userInput  = ui[3:0];
        gc.pulse2s    = p2;
        gc.timeout    = to;
        model_step(r, li, sp, ui, p2, to);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // From LOAD/SHOW, play one round: 0 = correct, 1 = wrong digit, 2 = out-of-range digit.
    task automatic play_round(input int mode);
        int n;
        int ui;
        n = 0;
        while (m_state != S_SHOW && n < 10) begin cyc(0, 1, 0, 0, 0, 0); n++; end
        if (m_state != S_SHOW) chk("reach_show", m_state, S_SHOW);
        cyc(0, 1, 0, 0, 1, 0);
        ui = (mode == 0) ? m_digit : (mode == 1) ? (m_digit + 1) % 10 : 12;
        cyc(0, 1, 0, ui, 0, 0);
        cyc(0, 1, 1, ui, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m_digit = 0; m_guess = 0;
        // Reset overrides an active session and a start press.
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("rst_rand", gc.randDigit, 15);
        chk("rst_player", gc.playerDigit, 15);
        chk("rst_ten", gc.timerEnable, 0);

        // First game: seed digit is 1.
        cyc(0, 1, 1, 0, 0, 0);
        chk("start_reconf", gc.timerReconfig, 1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("load_reconf_once", gc.timerReconfig, 0);
        chk("seed_digit", gc.randDigit, 1);
        chk("show_two", gc.twoSecEnable, 1);
        cyc(0, 1, 1, 0, 0, 0);   // start ignored in SHOW
        chk("show_hold", gc.twoSecEnable, 1);
        cyc(0, 1, 0, 0, 1, 0);
        chk("guess_ten", gc.timerEnable, 1);
        chk("guess_blank", gc.randDigit, 15);
        cyc(0, 1, 0, 1, 0, 0);
        chk("guess_player", gc.playerDigit, 1);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("first_score", gc.scoreOnes, 1);
        chk("first_level", gc.gameLevel, 1);
        chk("first_reload", gc.timerReconfig, 1);

        // Level saturation.
        for (int i = 0; i < 3; i++) play_round(0);
        chk("level_at_3", gc.gameLevel, 3);
        play_round(0);
        chk("level_sat", gc.gameLevel, 3);

        // Score saturation at 99.
        for (int i = 5; i < 99; i++) play_round(0);
        chk("score99_t", gc.scoreTens, 9);
        chk("score99_o", gc.scoreOnes, 9);
        play_round(0);
        chk("score_sat_t", gc.scoreTens, 9);
        chk("score_sat_o", gc.scoreOnes, 9);

        // Misses until game over.
        n = 0;
        while (m_state != S_OVER && n < 5) begin play_round(n == 0 ? 2 : 1); n++; end
`ifdef GC_LIVES_EN
        chk("misses_to_over", n, 3);
`else
        chk("misses_to_over", n, 1);
`endif
        chk("over_ten", gc.timerEnable, 0);
        chk("over_score", gc.scoreTens, 9);
        cyc(0, 1, 1, 0, 0, 0);
        chk("logout_pulse", gc.GCLogout, 1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("logout_once", gc.GCLogout, 0);

        // Timeout beats a simultaneous submit.
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 1, 1, m_digit, 0, 1);
        chk("to_ten", gc.timerEnable, 0);
        chk("to_player", gc.playerDigit, 15);
        cyc(0, 1, 0, 0, 0, 0);
        chk("to_score", gc.scoreOnes, 0);
        cyc(0, 1, 1, 0, 0, 0);

        // Session drop in SHOW.
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("drop_pre", gc.twoSecEnable, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("drop_two", gc.twoSecEnable, 0);
        chk("drop_rand", gc.randDigit, 15);

        // Reset in GUESS after scoring.
        cyc(0, 1, 1, 0, 0, 0);
        play_round(0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("pre_rst_ten", gc.timerEnable, 1);
        cyc(1, 1, 0, 0, 0, 0);
        chk("rst_g_ten", gc.timerEnable, 0);
        chk("rst_g_score", gc.scoreOnes, 0);
        chk("rst_g_level", gc.gameLevel, 0);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            bit r, li, sp, p2, to;
            int ui;
            r  = ($urandom_range(0, 199) == 0);
            li = ($urandom_range(0, 99) != 0);
            sp = ($urandom_range(0, 4) == 0);
            p2 = ($urandom_range(0, 3) == 0);
            to = ($urandom_range(0, 29) == 0);
            ui = (m_state == S_GUESS && $urandom_range(0, 1) == 1) ? m_digit : int'($urandom_range(0, 15));
            cyc(r, li, sp, ui, p2, to);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
